// File: rtl/sprite_pkg.sv
// sprite_pkg: shared widths, sprite indices, colours and sequencer state encoding
package sprite_pkg;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int C_W = 3;
  localparam int SPR_PLAYER = 0;
  localparam int SPR_ALIEN  = 1;
  localparam int SPR_BULLET = 2;
  localparam logic [C_W-1:0] COLOUR_BLACK = 3'b000;
  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t ERASE = 3'd1;
  localparam state_t GAP_E = 3'd2;
  localparam state_t DRAW  = 3'd3;
  localparam state_t GAP_D = 3'd4;
endpackage

// File: rtl/sprite_frame_sequencer_pixel_mux.sv
// sprite_pixel_mux: routes the selected sprite's pixel stream to the VGA port, blacking colour on erase
module sprite_pixel_mux
  import sprite_pkg::*;
#(
  parameter int N_SPR = 3,
  parameter int SW    = 2
) (
  input  logic [SW-1:0]        sel,
  input  logic                 plot,
  input  logic                 erase,
  input  logic [X_W*N_SPR-1:0] spr_x,
  input  logic [Y_W*N_SPR-1:0] spr_y,
  input  logic [C_W*N_SPR-1:0] spr_colour,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_plot
);
  // select the active sprite's pixel; everything is zero when no phase is running
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = COLOUR_BLACK;
    vga_plot   = plot;
    for (int i = 0; i < N_SPR; i++) begin
      if (plot && sel == SW'(i)) begin
        vga_x      = spr_x[i*X_W +: X_W];
        vga_y      = spr_y[i*Y_W +: Y_W];
        vga_colour = erase ? COLOUR_BLACK : spr_colour[i*C_W +: C_W];
      end
    end
  end
endmodule

// File: rtl/sprite_frame_sequencer.sv
// sprite_frame_sequencer: per-frame erase/draw scheduler driving sprite requests and the VGA write port
module sprite_frame_sequencer
  import sprite_pkg::*;
#(
  parameter int N_SPR   = 3,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic [N_SPR-1:0]     spr_done,
  input  logic [X_W*N_SPR-1:0] spr_x,
  input  logic [Y_W*N_SPR-1:0] spr_y,
  input  logic [C_W*N_SPR-1:0] spr_colour,
  output logic [N_SPR-1:0]     draw_signal,
  output logic [N_SPR-1:0]     erase_signal,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_plot,
  output logic                 busy,
  output logic                 overrun,
  output logic                 timeout_err
);
  localparam int SW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              first_q, first_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              timeout_err_q, timeout_err_d;
  logic [N_SPR-1:0]  draw_q, draw_d;
  logic [N_SPR-1:0]  erase_q, erase_d;
  logic [N_SPR-1:0]  sel_oh;
  logic              phase, done_sel, expired;
  assign sel_oh   = N_SPR'(1) << sel_q;
  assign phase    = (state_q == ERASE) || (state_q == DRAW);
  assign done_sel = |(spr_done & sel_oh);
  assign expired  = tcnt_q == TW'(TIMEOUT);
  // sequencing: walk sprites in order, erase then draw each, with a one-cycle quiet gap after every phase
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    first_d       = first_q;
    tcnt_d        = phase ? tcnt_q + 1'b1 : tcnt_q;
    overrun_d     = overrun_q | (frame_tick & busy_q);
    timeout_err_d = timeout_err_q | (phase & ~done_sel & expired);
    case (state_q)
      IDLE: if (frame_tick) begin
        state_d = first_q ? DRAW : ERASE;
        sel_d   = '0;
        tcnt_d  = '0;
      end
      ERASE: if (done_sel || expired) state_d = GAP_E;
      GAP_E: begin
        state_d = DRAW;
        tcnt_d  = '0;
      end
      DRAW: if (done_sel || expired) state_d = GAP_D;
      GAP_D: if (sel_q == SW'(N_SPR - 1)) begin
        state_d = IDLE;
        first_d = 1'b0;
      end else begin
        state_d = first_q ? DRAW : ERASE;
        sel_d   = sel_q + 1'b1;
        tcnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = state_d != IDLE;
    draw_d  = (state_q == DRAW) ? sel_oh : '0;
    erase_d = (state_q == ERASE) ? sel_oh : '0;
  end
  // state and registered outputs; reset aborts a frame immediately and clears sticky flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      tcnt_q        <= '0;
      first_q       <= 1'b1;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      draw_q        <= '0;
      erase_q       <= '0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      tcnt_q        <= tcnt_d;
      first_q       <= first_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      draw_q        <= draw_d;
      erase_q       <= erase_d;
    end
  end
  assign draw_signal  = draw_q;
  assign erase_signal = erase_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_err_q;
  sprite_pixel_mux #(.N_SPR(N_SPR), .SW(SW)) u_mux (
    .sel        (sel_q),
    .plot       (phase),
    .erase      (state_q == ERASE),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_colour (spr_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );
endmodule
